// File: rtl/pipe_skid_reg_pkg.sv
// Shared pipeline definitions: the stage occupancy type and the saturation
// value used by performance counters of the default width.
package pipe_skid_reg_pkg;

   // Number of words held by a two-entry elastic stage (0..2).
   typedef logic [1:0] occ_t;

   // Default performance-counter width and its saturation value (all-ones).
   localparam int unsigned          BP_CNT_W   = 32;
   localparam logic [BP_CNT_W-1:0]  BP_CNT_SAT = '1;

   // Occupancy from the two entry valid bits.
   function automatic occ_t occ_count(input logic main_v, input logic skid_v);
      return occ_t'({1'b0, main_v}) + occ_t'({1'b0, skid_v});
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; reused for performance
// counters across the pipeline.
module sat_counter
   import pipe_skid_reg_pkg::*;
#(
   parameter int CNT_W = BP_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count
);

   localparam logic [CNT_W-1:0] SAT_MAX = '1;

   logic [CNT_W-1:0] r_count;

   // Count register: clear wins over increment; holds once all-ones.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      if (!rst) begin
         r_count <= '0;
      end else if (clr) begin
         r_count <= '0;
      end else if (inc && (r_count != SAT_MAX)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign count = r_count;

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic two-entry pipeline stage (main + skid) with a registered ready,
// global stall/flush control and a saturating backpressure counter.
module pipe_skid_reg
   import pipe_skid_reg_pkg::*;
#(
   parameter int BW            = 256,
   parameter int CNT_W         = 32,
   parameter int ZERO_ON_FLUSH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [BW-1:0]    in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [BW-1:0]    out_data,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] bp_cnt,
   input  logic             cnt_clr
);

   logic          r_main_v;
   logic [BW-1:0] r_main_d;
   logic          r_skid_v;
   logic [BW-1:0] r_skid_d;
   logic          r_in_ready_q;

   logic w_in_fire;
   logic w_out_fire;
   logic w_bp_inc;

   // Handshake qualifiers: stall and flush block both directions.
   assign in_ready   = r_in_ready_q & ~stall & ~flush;
   assign out_valid  = r_main_v & ~stall;
   assign out_data   = r_main_d;
   assign occupancy  = occ_count(r_main_v, r_skid_v);
   assign w_in_fire  = in_valid & in_ready;
   assign w_out_fire = out_valid & out_ready;
   assign w_bp_inc   = r_main_v & (stall | ~out_ready) & ~flush;

   // Entry state: reset, then flush, then stall, then normal skid operation.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_main_v     <= 1'b0;
         r_main_d     <= '0;
         r_skid_v     <= 1'b0;
         r_skid_d     <= '0;
         r_in_ready_q <= 1'b0;
      end else if (flush) begin
         r_main_v     <= 1'b0;
         r_skid_v     <= 1'b0;
         r_in_ready_q <= 1'b1;
         if (ZERO_ON_FLUSH != 0) begin
            r_main_d <= '0;
            r_skid_d <= '0;
         end
      end else if (stall) begin
         // Entries frozen; ready still tracks skid so it rises after reset.
         r_in_ready_q <= ~r_skid_v;
      end else if (!r_main_v || w_out_fire) begin
         // Main is free this cycle: refill from skid first to keep order.
         r_in_ready_q <= 1'b1;
         if (r_skid_v) begin
            r_main_d <= r_skid_d;
            r_main_v <= 1'b1;
            r_skid_v <= 1'b0;
         end else if (w_in_fire) begin
            r_main_d <= in_data;
            r_main_v <= 1'b1;
         end else begin
            r_main_v <= 1'b0;
         end
      end else if (w_in_fire) begin
         // Main blocked: the in-flight word lands in skid, ready drops.
         r_skid_d     <= in_data;
         r_skid_v     <= 1'b1;
         r_in_ready_q <= 1'b0;
      end else begin
         r_in_ready_q <= ~r_skid_v;
      end
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_bp_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (w_bp_inc),
      .clr   (cnt_clr),
      .count (bp_cnt)
   );

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Elastic pipeline stage register: the handshaked successor to the plain stall/flush stage register. It holds up to two BW-bit words, a main entry and a skid entry, so that `in_ready` can be a registered signal and the stage runs at full throughput under valid/ready backpressure. It keeps global stall (freeze) and flush (kill) control and adds a saturating backpressure-cycle counter for performance monitoring. It sits between any two pipeline stages of the core.

## Interface
Parameters:
- BW, 256, data width in bits
- CNT_W, 32, width of the backpressure counter
- ZERO_ON_FLUSH, 1, 1 = flush also zeroes stored data; 0 = flush clears valids only

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-low
- stall  in  1  freeze: no transfer in or out, state held
- flush  in  1  kill all held entries; priority over stall
- in_valid  in  1  upstream word valid
- in_ready  out  1  stage can accept; equals in_ready_q & ~stall & ~flush
- in_data  in  BW  upstream word
- out_valid  out  1  equals main_v & ~stall
- out_ready  in  1  downstream accepts
- out_data  out  BW  main entry data
- occupancy  out  2  main_v + skid_v (0..2)
- bp_cnt  out  CNT_W  saturating count of backpressure cycles
- cnt_clr  in  1  synchronous clear of bp_cnt

## Operation
- State: main_v, main_d, skid_v, skid_d, in_ready_q, bp_cnt.
- Reset (rst low at an edge): all valids 0, all data 0, in_ready_q 0, bp_cnt 0. Outputs during and after reset: out_valid 0, out_data 0, in_ready 0, occupancy 0, bp_cnt 0. in_ready_q becomes 1 at the first edge with rst high.
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Flush (highest priority after reset):
  - main_v and skid_v go to 0; in_ready_q goes to 1.
  - If ZERO_ON_FLUSH, main_d and skid_d go to 0; otherwise data is held.
  - in_ready is forced 0 in the flush cycle, so a word presented alongside flush is dropped and never accepted.
- Stall (no flush): all state held; in_ready and out_valid forced 0, so no transfer occurs in either direction.
- Normal cycle, when main_v = 0 or out_fire:
  - if skid_v: main is loaded from skid and skid_v goes to 0;
  - else if in_fire: main is loaded from in_data;
  - else main_v goes to 0.
- Normal cycle, when main_v = 1 and out_fire = 0: if in_fire, in_data goes to skid and skid_v goes to 1.
- in_fire while skid_v = 1 is impossible, because in_ready_q = 0.
- in_ready_q next value is the inverse of the next skid_v.
- Ordering: words leave in arrival order; nothing is duplicated or lost except by flush.
- bp_cnt:
  - cnt_clr has priority and sets it to 0.
  - Otherwise it increments when main_v & (stall | ~out_ready) & ~flush.
  - It saturates at 2^CNT_W-1 and does not wrap.
  - flush does not clear it.

## Timing
- Latency is 1 cycle from in_fire to out_valid when the stage is empty.
- Throughput is 1 word/cycle with out_ready held high.
- in_ready responds to backpressure one cycle late; the skid entry absorbs the one word already in flight.
- After out_ready rises with occupancy 2:
  - main drains first, then skid moves into main;
  - in_ready returns to 1 on the edge where skid empties.
- rst low mid-transfer wins over flush, stall and handshakes in the same cycle; the held words are lost.
- flush and stall together behave as flush.
- in_valid may drop without a transfer; there is no requirement for upstream to hold a word.

## Structure
- Shared pipeline package: the occupancy typedef (2-bit) and a localparam for the counter's saturation value (all-ones).
- One sub-module, `sat_counter` (CNT_W, inc, clr, count), reused for other performance counters.
- The skid datapath stays inline.

## Test plan
- Reset then stream: rst low 3 cycles; in_valid=1 with data 1,2,3...; out_ready=1 -> in_ready 0 during reset, 1 after; out_data 1,2,3 on consecutive cycles, one cycle after each accept; occupancy stays at 1.
- Backpressure: stream 0xA,0xB,0xC; out_ready=0 from cycle 2 -> occupancy reaches 2, in_ready falls the next cycle, 0xC is held upstream; on release outputs are 0xA,0xB,0xC in order with no loss.
- Flush with both entries full and in_valid=1 with 0xD -> next cycle occupancy 0, out_valid 0, in_ready 1, out_data 0 (ZERO_ON_FLUSH=1); 0xD is never output.
- Stall: occupancy 2, stall high 4 cycles -> out_valid 0, in_ready 0, state unchanged, bp_cnt +4; flush during stall clears both entries.
- Counter: CNT_W=4, out_ready=0 with main_v=1 for 20 cycles -> bp_cnt saturates at 15; cnt_clr -> 0 the next cycle.
